// File: rtl/dac_sample_scheduler.sv
// Paces a buffered 16-bit sample stream into dac_spi, one request per sample tick.
// Underruns replay the previous sample; sticky flags report underrun, late ticks and request timeouts.
module dac_sample_scheduler #(
  parameter int          CLKS_PER_SAMPLE = 128,
  parameter int          FIFO_DEPTH      = 8,
  parameter int          REQ_TIMEOUT     = 16,
  parameter logic [15:0] IDLE_CODE       = 16'h8000
) (
  input  logic                          clock_in,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [15:0]                   in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [15:0]                   dac_data,
  output logic                          dac_rq,
  input  logic                          dac_st,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          late,
  output logic                          timeout,
  input  logic                          clear_status
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_SAMPLE);
  localparam int RW = $clog2(REQ_TIMEOUT) + 1;

  localparam logic [CW-1:0] TICK_LAST  = CW'(CLKS_PER_SAMPLE - 1);
  localparam logic [RW-1:0] REQ_LAST   = RW'(REQ_TIMEOUT - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_BUSY = 2'b10
  } state_t;

  logic [CW-1:0] tick_cnt_r;
  logic          tick_s;

  logic [15:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [LW-1:0] level_next_s;
  logic          in_ready_r;
  logic          wr_en_s;
  logic          pop_s;
  logic [15:0]   head_s;

  state_t        state_r;
  state_t        state_next_s;
  logic          rq_r;
  logic          rq_next_s;
  logic [15:0]   data_r;
  logic [15:0]   data_next_s;
  logic [15:0]   last_r;
  logic [15:0]   last_next_s;
  logic [RW-1:0] req_cnt_r;
  logic [RW-1:0] req_cnt_next_s;
  logic          underrun_set_s;
  logic          late_set_s;
  logic          timeout_set_s;
  logic          underrun_r;
  logic          late_r;
  logic          timeout_r;

  // Tick strobe: last count of the sample period, only while enabled.
  always_comb begin
    tick_s = enable && (tick_cnt_r == TICK_LAST);
  end

  // Sample-period counter; held at zero while disabled.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      tick_cnt_r <= {CW{1'b0}};
    end else if (!enable) begin
      tick_cnt_r <= {CW{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= {CW{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + CW'(1);
    end
  end

  // FIFO control: write accepted only when not full; reads come from the scheduler.
  always_comb begin
    wr_en_s = in_valid && in_ready_r;
    head_s  = mem_r[rd_ptr_r];
    case ({wr_en_s, pop_s})
      2'b10:   level_next_s = level_r + LW'(1);
      2'b01:   level_next_s = level_r - LW'(1);
      default: level_next_s = level_r;
    endcase
  end

  // FIFO storage; no reset needed because occupancy gates every read.
  always_ff @(posedge clock_in) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // FIFO pointers, occupancy and a registered ready that tracks next-cycle fullness.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      level_r    <= {LW{1'b0}};
      in_ready_r <= 1'b1;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r    <= level_next_s;
      in_ready_r <= (level_next_s != FULL_LEVEL);
    end
  end

  // Scheduler next-state and output decode.
  always_comb begin
    state_next_s   = state_r;
    rq_next_s      = rq_r;
    data_next_s    = data_r;
    last_next_s    = last_r;
    req_cnt_next_s = req_cnt_r;
    pop_s          = 1'b0;
    underrun_set_s = 1'b0;
    timeout_set_s  = 1'b0;
    late_set_s     = tick_s && (state_r != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        rq_next_s = 1'b0;
        if (tick_s) begin
          if (level_r != {LW{1'b0}}) begin
            pop_s       = 1'b1;
            data_next_s = head_s;
            last_next_s = head_s;
          end else begin
            data_next_s    = last_r;
            underrun_set_s = 1'b1;
          end
          rq_next_s      = 1'b1;
          req_cnt_next_s = {RW{1'b0}};
          state_next_s   = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dac_st) begin
          rq_next_s    = 1'b0;
          state_next_s = ST_BUSY;
        end else if (req_cnt_r == REQ_LAST) begin
          rq_next_s     = 1'b0;
          timeout_set_s = 1'b1;
          state_next_s  = ST_IDLE;
        end else begin
          rq_next_s      = 1'b1;
          req_cnt_next_s = req_cnt_r + RW'(1);
          state_next_s   = ST_REQ;
        end
      end
      ST_BUSY: begin
        rq_next_s = 1'b0;
        if (!dac_st) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      default: begin
        rq_next_s    = 1'b0;
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Scheduler state and DAC-side output registers.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      rq_r      <= 1'b0;
      data_r    <= IDLE_CODE;
      last_r    <= IDLE_CODE;
      req_cnt_r <= {RW{1'b0}};
    end else begin
      state_r   <= state_next_s;
      rq_r      <= rq_next_s;
      data_r    <= data_next_s;
      last_r    <= last_next_s;
      req_cnt_r <= req_cnt_next_s;
    end
  end

  // Sticky status; a set in the same cycle as clear_status wins.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      underrun_r <= 1'b0;
      late_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      underrun_r <= underrun_set_s | (underrun_r & ~clear_status);
      late_r     <= late_set_s     | (late_r     & ~clear_status);
      timeout_r  <= timeout_set_s  | (timeout_r  & ~clear_status);
    end
  end

  assign in_ready   = in_ready_r;
  assign fifo_level = level_r;
  assign dac_data   = data_r;
  assign dac_rq     = rq_r;
  assign underrun   = underrun_r;
  assign late       = late_r;
  assign timeout    = timeout_r;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed-plus-random bench for dac_sample_scheduler with a behavioural dac_spi responder
// and a queue-based model of the expected sample stream.
module tb_dac_sample_scheduler;

  localparam int MODE_NORMAL = 0;
  localparam int MODE_DEAD   = 1;
  localparam int MODE_LONG   = 2;

  logic        clock_in;
  logic        reset;
  logic        enable;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dac_data;
  logic        dac_rq;
  logic        dac_st;
  logic [3:0]  fifo_level;
  logic        underrun;
  logic        late;
  logic        timeout;
  logic        clear_status;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          spi_mode = MODE_DEAD;
  bit          spi_busy = 1'b0;
  logic [15:0] cap_data[$];
  int          cap_cyc[$];
  logic [15:0] model_q[$];

  dac_sample_scheduler dut (
    .clock_in     (clock_in),
    .reset        (reset),
    .enable       (enable),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .dac_data     (dac_data),
    .dac_rq       (dac_rq),
    .dac_st       (dac_st),
    .fifo_level   (fifo_level),
    .underrun     (underrun),
    .late         (late),
    .timeout      (timeout),
    .clear_status (clear_status)
  );

  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  always @(posedge clock_in) cyc <= cyc + 1;

  // dac_spi stand-in: takes the sample one clock after dac_rq, stays busy for a frame.
  initial begin
    dac_st = 1'b0;
    forever begin
      @(negedge clock_in);
      if (dac_rq === 1'b1 && spi_mode != MODE_DEAD) begin
        cap_data.push_back(dac_data);
        cap_cyc.push_back(cyc);
        spi_busy = 1'b1;
        dac_st   = 1'b1;
        repeat ((spi_mode == MODE_LONG) ? 200 : 96) @(negedge clock_in);
        dac_st   = 1'b0;
        spi_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    @(negedge clock_in);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clock_in);
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clock_in);
    clear_status = 1'b1;
    @(negedge clock_in);
    clear_status = 1'b0;
  endtask

  task automatic wait_caps(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (cap_data.size() < n && k < budget) begin
      @(negedge clock_in);
      k++;
    end
    chk(tag, 32'(cap_data.size() >= n), 32'd1);
  endtask

  task automatic wait_rq(input int budget, input string tag, output int at);
    int k;
    k = 0;
    while (dac_rq !== 1'b1 && k < budget) begin
      @(negedge clock_in);
      k++;
    end
    chk(tag, 32'(dac_rq), 32'd1);
    at = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((spi_busy || dac_rq === 1'b1 || dac_st === 1'b1) && k < 400) begin
      @(negedge clock_in);
      k++;
    end
    chk(tag, 32'(k < 400), 32'd1);
    repeat (4) @(negedge clock_in);
  endtask

  initial begin
    int          c0;
    int          r0;
    int          r1;
    int          hi;
    logic [15:0] d;

    reset        = 1'b1;
    enable       = 1'b0;
    in_data      = 16'h0000;
    in_valid     = 1'b0;
    clear_status = 1'b0;
    repeat (3) @(negedge clock_in);
    chk("rst_rq",       32'(dac_rq),     32'd0);
    chk("rst_data",     32'(dac_data),   32'h8000);
    chk("rst_ready",    32'(in_ready),   32'd1);
    chk("rst_level",    32'(fifo_level), 32'd0);
    chk("rst_flags",    32'({underrun, late, timeout}), 32'd0);
    reset = 1'b0;

    // T1: reset while a request is pending
    spi_mode = MODE_DEAD;
    push(16'($urandom_range(0, 16'h7FFF)));
    push(16'($urandom_range(0, 16'h7FFF)));
    chk("t1_level_pre", 32'(fifo_level), 32'd2);
    @(negedge clock_in);
    enable = 1'b1;
    wait_rq(200, "t1_rq_rise", r0);
    repeat (3) @(negedge clock_in);
    #2 reset = 1'b1;
    #1;
    chk("t1_rq",    32'(dac_rq),     32'd0);
    chk("t1_data",  32'(dac_data),   32'h8000);
    chk("t1_ready", 32'(in_ready),   32'd1);
    chk("t1_level", 32'(fifo_level), 32'd0);
    chk("t1_flags", 32'({underrun, late, timeout}), 32'd0);
    enable = 1'b0;
    @(negedge clock_in);
    reset = 1'b0;
    repeat (2) @(negedge clock_in);

    // T2: two queued samples, one frame per tick
    spi_mode = MODE_NORMAL;
    cap_data.delete();
    cap_cyc.delete();
    push(16'h1234);
    push(16'h5678);
    chk("t2_level2", 32'(fifo_level), 32'd2);
    @(negedge clock_in);
    enable = 1'b1;
    c0 = cyc;
    wait_caps(1, 200, "t2_frame0");
    chk("t2_latency", 32'(cap_cyc[0] - c0), 32'd128);
    chk("t2_data0",   32'(cap_data[0]),     32'h1234);
    chk("t2_level1",  32'(fifo_level),      32'd1);
    wait_caps(2, 200, "t2_frame1");
    chk("t2_data1",   32'(cap_data[1]),             32'h5678);
    chk("t2_gap",     32'(cap_cyc[1] - cap_cyc[0]), 32'd128);
    chk("t2_level0",  32'(fifo_level),              32'd0);
    chk("t2_no_ur",   32'(underrun),                32'd0);

    // T3: empty FIFO replays the last sample
    wait_caps(3, 200, "t3_frame2");
    chk("t3_data",    32'(cap_data[2]),             32'h5678);
    chk("t3_gap",     32'(cap_cyc[2] - cap_cyc[1]), 32'd128);
    chk("t3_ur_set",  32'(underrun),                32'd1);
    chk("t3_no_late", 32'(late),                    32'd0);
    pulse_clear();
    chk("t3_ur_clr",  32'(underrun), 32'd0);
    enable = 1'b0;
    wait_idle("t3_idle");

    // T4: overfill with random data, then drain in order
    cap_data.delete();
    cap_cyc.delete();
    model_q.delete();
    for (int i = 0; i < 9; i++) begin
      d = 16'($urandom_range(0, 16'hFFFF));
      push(d);
      if (model_q.size() < 8) model_q.push_back(d);
      chk($sformatf("t4_ready_%0d", i), 32'(in_ready),   32'(model_q.size() < 8));
      chk($sformatf("t4_level_%0d", i), 32'(fifo_level), 32'(model_q.size()));
    end
    @(negedge clock_in);
    enable = 1'b1;
    wait_caps(8, 1200, "t4_frames");
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < cap_data.size()) chk($sformatf("t4_data_%0d", i), 32'(cap_data[i]), 32'(model_q[i]));
    end
    wait_idle("t4_idle");
    chk("t4_level_end", 32'(fifo_level), 32'd0);
    chk("t4_no_ur",     32'(underrun),   32'd0);
    chk("t4_ready_end", 32'(in_ready),   32'd1);

    // T5: dac_spi never answers
    spi_mode = MODE_DEAD;
    pulse_clear();
    @(negedge clock_in);
    enable = 1'b1;
    wait_rq(200, "t5_rq_rise", r0);
    hi = 0;
    while (dac_rq === 1'b1 && hi < 100) begin
      @(negedge clock_in);
      hi++;
    end
    chk("t5_rq_width", 32'(hi),      32'd16);
    chk("t5_timeout",  32'(timeout), 32'd1);
    chk("t5_underrun", 32'(underrun), 32'd1);
    wait_rq(200, "t5_retry", r1);
    chk("t5_retry_gap", 32'(r1 - r0), 32'd128);
    enable = 1'b0;
    repeat (20) @(negedge clock_in);
    chk("t5_rq_low",  32'(dac_rq), 32'd0);
    chk("t5_no_late", 32'(late),   32'd0);
    pulse_clear();
    chk("t5_clr", 32'({underrun, late, timeout}), 32'd0);

    // T6: overlong frame makes the next tick late and drops it
    spi_mode = MODE_LONG;
    cap_data.delete();
    cap_cyc.delete();
    model_q.delete();
    for (int i = 0; i < 3; i++) begin
      d = 16'($urandom_range(0, 16'hFFFF));
      push(d);
      model_q.push_back(d);
    end
    @(negedge clock_in);
    enable = 1'b1;
    wait_caps(1, 200, "t6_frame0");
    chk("t6_data0",  32'(cap_data[0]), 32'(model_q[0]));
    chk("t6_level2", 32'(fifo_level),  32'd2);
    repeat (140) @(negedge clock_in);
    chk("t6_late",      32'(late),            32'd1);
    chk("t6_level_hold", 32'(fifo_level),     32'd2);
    chk("t6_no_frame",  32'(cap_data.size()), 32'd1);
    wait_caps(2, 200, "t6_frame1");
    chk("t6_data1",  32'(cap_data[1]),             32'(model_q[1]));
    chk("t6_gap",    32'(cap_cyc[1] - cap_cyc[0]), 32'd256);
    chk("t6_level1", 32'(fifo_level),              32'd1);
    enable = 1'b0;
    wait_idle("t6_idle");
    chk("t6_no_ur", 32'(underrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
